// File: rtl/isa_pkg.sv
// ISA constants for the 20-bit instruction set: opcodes, ALU encodings,
// instruction field positions and ID/EX control-word bit indices.
package isa_pkg;

    localparam int INSTR_W = 20;
    localparam int REG_AW  = 4;
    localparam int CTRL_W  = 10;

    localparam logic [3:0] OP_RALU  = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;
    localparam logic [3:0] OP_JAL   = 4'h6;
    localparam logic [3:0] OP_LUI   = 4'h7;
    localparam logic [3:0] OP_NOP   = 4'hF;

    localparam logic [3:0] FUNCT_MAX = 4'h7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam int OP_HI    = 19;
    localparam int OP_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 12;
    localparam int RS1_HI   = 11;
    localparam int RS1_LO   = 8;
    localparam int RS2_HI   = 7;
    localparam int RS2_LO   = 4;
    localparam int FUNCT_HI = 3;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 7;
    localparam int IMM_LO   = 0;

    localparam int CTRL_REGWRITE = 9;
    localparam int CTRL_MEMREAD  = 8;
    localparam int CTRL_MEMWRITE = 7;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_BRANCHNE = 5;
    localparam int CTRL_JUMP     = 4;
    localparam int CTRL_ALUSRC   = 3;
    localparam int CTRL_ALU_HI   = 2;
    localparam int CTRL_ALU_LO   = 0;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 20'hF0000;

    function automatic logic is_legal(input logic [INSTR_W-1:0] instr);
        logic [3:0] op;
        logic [3:0] funct;
        op    = instr[OP_HI:OP_LO];
        funct = instr[FUNCT_HI:FUNCT_LO];
        case (op)
            OP_RALU:                            return (funct <= FUNCT_MAX);
            OP_ADDI, OP_LOAD, OP_STORE, OP_BEQ,
            OP_BNE, OP_JAL, OP_LUI, OP_NOP:     return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/register_file.sv
// NREG x DATA_W register file: two async read ports with write-through
// bypass, one sync write port; r0 always reads zero.
module register_file
    import isa_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int unsigned NREG   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    always_comb begin
        if (ra1 == '0)
            rd1 = '0;
        else if (we && wa == ra1)
            rd1 = wd;
        else
            rd1 = regs[ra1];

        if (ra2 == '0)
            rd2 = '0;
        else if (we && wa == ra2)
            rd2 = wd;
        else
            rd2 = regs[ra2];
    end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: field split, control generation, register read,
// load-use hazard detection and the ID/EX pipeline register.
module decode_stage
    import isa_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          PC_W   = 15,
    parameter int unsigned NREG   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] InstrD,
    input  logic [PC_W-1:0]    PCD,
    input  logic               PCSrcE,
    input  logic               RegWriteW,
    input  logic [REG_AW-1:0]  RdW,
    input  logic [DATA_W-1:0]  ResultW,
    output logic               StallFD,
    output logic               IllegalD,
    output logic [CTRL_W-1:0]  CtrlE,
    output logic [DATA_W-1:0]  RD1E,
    output logic [DATA_W-1:0]  RD2E,
    output logic [DATA_W-1:0]  ImmExtE,
    output logic [REG_AW-1:0]  Rs1E,
    output logic [REG_AW-1:0]  Rs2E,
    output logic [REG_AW-1:0]  RdE,
    output logic [PC_W-1:0]    PCE
);

    logic [INSTR_W-1:0] instr;
    logic [3:0]         op;
    logic [REG_AW-1:0]  rd, rs1, rs2;
    logic [CTRL_W-1:0]  ctrl;
    logic [DATA_W-1:0]  imm_ext;
    logic               uses_rs2;
    logic [DATA_W-1:0]  rd1, rd2;

    // Illegal encodings are replaced by the NOP word so every field decodes to zero.
    always_comb begin
        IllegalD = !is_legal(InstrD);
        instr    = IllegalD ? NOP_INSTR : InstrD;
        op       = instr[OP_HI:OP_LO];
    end

    always_comb begin
        ctrl     = '0;
        rd       = instr[RD_HI:RD_LO];
        rs1      = instr[RS1_HI:RS1_LO];
        rs2      = instr[RS2_HI:RS2_LO];
        uses_rs2 = 1'b0;
        imm_ext  = {{(DATA_W-8){instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
        case (op)
            OP_RALU: begin
                ctrl[CTRL_REGWRITE]           = 1'b1;
                ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = instr[FUNCT_LO+2:FUNCT_LO];
                uses_rs2                      = 1'b1;
            end
            OP_ADDI: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
            end
            OP_LOAD: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_MEMREAD]  = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
            end
            OP_STORE: begin
                ctrl[CTRL_MEMWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                rs2                 = instr[RD_HI:RD_LO];
                rd                  = '0;
                uses_rs2            = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl[CTRL_BRANCH]             = (op == OP_BEQ);
                ctrl[CTRL_BRANCHNE]           = (op == OP_BNE);
                ctrl[CTRL_ALU_HI:CTRL_ALU_LO] = ALU_SUB;
                rs2                           = instr[RD_HI:RD_LO];
                rd                            = '0;
                uses_rs2                      = 1'b1;
            end
            OP_JAL: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_JUMP]     = 1'b1;
            end
            OP_LUI: begin
                ctrl[CTRL_REGWRITE] = 1'b1;
                ctrl[CTRL_ALUSRC]   = 1'b1;
                imm_ext             = DATA_W'({instr[IMM_HI:IMM_LO], 8'h00});
            end
            default: ctrl = '0;
        endcase
    end

    assign StallFD = CtrlE[CTRL_MEMREAD] && (RdE != '0) &&
                     ((RdE == rs1) || (uses_rs2 && (RdE == rs2)));

    register_file #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_register_file (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs1),
        .ra2   (rs2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (RegWriteW),
        .wa    (RdW),
        .wd    (ResultW)
    );

    // Reset, flush and stall all load the same all-zero bubble.
    always_ff @(posedge clk) begin
        if (reset || PCSrcE || StallFD) begin
            CtrlE   <= '0;
            RD1E    <= '0;
            RD2E    <= '0;
            ImmExtE <= '0;
            Rs1E    <= '0;
            Rs2E    <= '0;
            RdE     <= '0;
            PCE     <= '0;
        end else begin
            CtrlE   <= ctrl;
            RD1E    <= rd1;
            RD2E    <= rd2;
            ImmExtE <= imm_ext;
            Rs1E    <= rs1;
            Rs2E    <= rs2;
            RdE     <= rd;
            PCE     <= PCD;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: expected ID/EX contents are queued
// when an instruction is driven and compared after the following clock edge.
module tb_decode_stage;

    logic        clk;
    logic        reset;
    logic [19:0] InstrD;
    logic [14:0] PCD;
    logic        PCSrcE;
    logic        RegWriteW;
    logic [3:0]  RdW;
    logic [31:0] ResultW;
    logic        StallFD;
    logic        IllegalD;
    logic [9:0]  CtrlE;
    logic [31:0] RD1E, RD2E, ImmExtE;
    logic [3:0]  Rs1E, Rs2E, RdE;
    logic [14:0] PCE;

    decode_stage #(
        .DATA_W (32),
        .PC_W   (15),
        .NREG   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCSrcE    (PCSrcE),
        .RegWriteW (RegWriteW),
        .RdW       (RdW),
        .ResultW   (ResultW),
        .StallFD   (StallFD),
        .IllegalD  (IllegalD),
        .CtrlE     (CtrlE),
        .RD1E      (RD1E),
        .RD2E      (RD2E),
        .ImmExtE   (ImmExtE),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .PCE       (PCE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [3:0]  rd;
        logic [14:0] pc;
    } ev_t;

    localparam ev_t BUBBLE = '0;

    ev_t         sb[$];
    ev_t         got, exp_v;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_regs [16];

    function automatic ev_t mk(input logic [9:0] ctrl, input logic [31:0] rd1,
                               input logic [31:0] rd2, input logic [31:0] imm,
                               input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic [3:0] rd, input logic [14:0] pc);
        ev_t e;
        e.ctrl = ctrl; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.pc = pc;
        return e;
    endfunction

    function ev_t observe();
        return mk(CtrlE, RD1E, RD2E, ImmExtE, Rs1E, Rs2E, RdE, PCE);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            InstrD = 20'($urandom);
            PCD    = 15'($urandom);
            cyc();
            got = observe();
            checks++;
            if (got !== BUBBLE) begin
                failures++;
                $display("FAIL reset_outputs got=%h exp=%h", got, BUBBLE);
            end
            checks++;
            if (StallFD !== 1'b0) begin
                failures++;
                $display("FAIL reset_stall got=%b exp=0", StallFD);
            end
        end
        reset  = 1'b0;
        InstrD = 20'h03121;
        PCD    = 15'h010;
        #1;
        checks++;
        if (IllegalD !== 1'b0) begin
            failures++;
            $display("FAIL sub_legal got=%b exp=0", IllegalD);
        end
        sb.push_back(mk(10'h201, ref_regs[1], ref_regs[2], 32'h21, 4'd1, 4'd2, 4'd3, 15'h010));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL sub_decode got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_writeback();
        logic [3:0]  wr_idx [5] = '{4'd1, 4'd2, 4'd9, 4'd10, 4'd4};
        logic [31:0] wr_val [5] = '{32'hA, 32'hB, 32'h99, 32'hAA, 32'h44};
        for (int i = 0; i < 5; i++) begin
            RegWriteW = 1'b1;
            RdW       = wr_idx[i];
            ResultW   = wr_val[i];
            InstrD    = 20'hF0000;
            PCD       = 15'(32'h20 + i);
            sb.push_back(mk(10'h000, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, PCD));
            cyc();
            ref_regs[wr_idx[i]] = wr_val[i];
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL nop_during_write got=%h exp=%h", got, exp_v);
            end
        end
        RegWriteW = 1'b0;
        InstrD    = 20'h03120;
        PCD       = 15'h028;
        sb.push_back(mk(10'h200, ref_regs[1], ref_regs[2], 32'h20, 4'd1, 4'd2, 4'd3, 15'h028));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL regfile_readback got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_bypass();
        RegWriteW = 1'b1;
        RdW       = 4'd5;
        ResultW   = 32'h1234;
        InstrD    = 20'h165FF;
        PCD       = 15'h030;
        sb.push_back(mk(10'h208, 32'h1234, ref_regs[15], 32'hFFFFFFFF, 4'd5, 4'd15, 4'd6, 15'h030));
        cyc();
        ref_regs[5] = 32'h1234;
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL addi_bypass got=%h exp=%h", got, exp_v);
        end
        RegWriteW = 1'b0;
        InstrD    = 20'h07500;
        PCD       = 15'h031;
        sb.push_back(mk(10'h200, ref_regs[5], 32'h0, 32'h0, 4'd5, 4'd0, 4'd7, 15'h031));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL write_committed got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_load_use();
        InstrD = 20'h24100;
        PCD    = 15'h040;
        #1;
        checks++;
        if (StallFD !== 1'b0) begin
            failures++;
            $display("FAIL load_no_stall got=%b exp=0", StallFD);
        end
        sb.push_back(mk(10'h308, ref_regs[1], 32'h0, 32'h0, 4'd1, 4'd0, 4'd4, 15'h040));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL load_decode got=%h exp=%h", got, exp_v);
        end
        InstrD = 20'h07410;
        PCD    = 15'h041;
        #1;
        checks++;
        if (StallFD !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall got=%b exp=1", StallFD);
        end
        sb.push_back(BUBBLE);
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL stall_bubble got=%h exp=%h", got, exp_v);
        end
        checks++;
        if (StallFD !== 1'b0) begin
            failures++;
            $display("FAIL stall_one_cycle got=%b exp=0", StallFD);
        end
        sb.push_back(mk(10'h200, ref_regs[4], ref_regs[1], 32'h10, 4'd4, 4'd1, 4'd7, 15'h041));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL held_add_issue got=%h exp=%h", got, exp_v);
        end
        InstrD = 20'h24100;
        PCD    = 15'h042;
        sb.push_back(mk(10'h308, ref_regs[1], 32'h0, 32'h0, 4'd1, 4'd0, 4'd4, 15'h042));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL load2_decode got=%h exp=%h", got, exp_v);
        end
        // ADDI carries 4 in its rs2 field but does not read rs2
        InstrD = 20'h17140;
        PCD    = 15'h043;
        #1;
        checks++;
        if (StallFD !== 1'b0) begin
            failures++;
            $display("FAIL unused_rs2_no_stall got=%b exp=0", StallFD);
        end
        sb.push_back(mk(10'h208, ref_regs[1], ref_regs[4], 32'h40, 4'd1, 4'd4, 4'd7, 15'h043));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL addi_after_load got=%h exp=%h", got, exp_v);
        end
    endtask

    task automatic test_flush();
        InstrD = 20'h24100;
        PCD    = 15'h050;
        sb.push_back(mk(10'h308, ref_regs[1], 32'h0, 32'h0, 4'd1, 4'd0, 4'd4, 15'h050));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL flush_load_decode got=%h exp=%h", got, exp_v);
        end
        InstrD = 20'h07410;
        PCD    = 15'h051;
        PCSrcE = 1'b1;
        #1;
        checks++;
        if (StallFD !== 1'b1) begin
            failures++;
            $display("FAIL flush_stall_comb got=%b exp=1", StallFD);
        end
        sb.push_back(BUBBLE);
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL flush_and_stall_bubble got=%h exp=%h", got, exp_v);
        end
        InstrD = 20'h165FF;
        PCD    = 15'h052;
        sb.push_back(BUBBLE);
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL flush_only_bubble got=%h exp=%h", got, exp_v);
        end
        PCSrcE = 1'b0;
    endtask

    task automatic test_illegal_r0();
        InstrD = 20'h81234;
        PCD    = 15'h060;
        #1;
        checks++;
        if (IllegalD !== 1'b1) begin
            failures++;
            $display("FAIL illegal_opcode got=%b exp=1", IllegalD);
        end
        sb.push_back(mk(10'h000, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 15'h060));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL illegal_opcode_nop got=%h exp=%h", got, exp_v);
        end
        InstrD = 20'h03129;
        PCD    = 15'h061;
        #1;
        checks++;
        if (IllegalD !== 1'b1) begin
            failures++;
            $display("FAIL illegal_funct got=%b exp=1", IllegalD);
        end
        sb.push_back(mk(10'h000, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd0, 15'h061));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL illegal_funct_nop got=%h exp=%h", got, exp_v);
        end
        InstrD = 20'h03127;
        PCD    = 15'h062;
        #1;
        checks++;
        if (IllegalD !== 1'b0) begin
            failures++;
            $display("FAIL funct7_legal got=%b exp=0", IllegalD);
        end
        sb.push_back(mk(10'h207, ref_regs[1], ref_regs[2], 32'h27, 4'd1, 4'd2, 4'd3, 15'h062));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL slt_decode got=%h exp=%h", got, exp_v);
        end
        for (int i = 0; i < 2; i++) begin
            RegWriteW = (i == 0);
            RdW       = 4'd0;
            ResultW   = 32'h5;
            InstrD    = 20'h01000;
            PCD       = 15'(32'h063 + i);
            sb.push_back(mk(10'h200, 32'h0, 32'h0, 32'h0, 4'd0, 4'd0, 4'd1, PCD));
            cyc();
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL r0_reads_zero pass=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
        RegWriteW = 1'b0;
    endtask

    task automatic test_store();
        InstrD = 20'h29100;
        PCD    = 15'h070;
        sb.push_back(mk(10'h308, ref_regs[1], 32'h0, 32'h0, 4'd1, 4'd0, 4'd9, 15'h070));
        cyc();
        got = observe(); exp_v = sb.pop_front(); checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL load_r9_decode got=%h exp=%h", got, exp_v);
        end
        InstrD = 20'h39204;
        PCD    = 15'h071;
        #1;
        checks++;
        if (StallFD !== 1'b1) begin
            failures++;
            $display("FAIL store_rs2_stall got=%b exp=1", StallFD);
        end
        sb.push_back(BUBBLE);
        sb.push_back(mk(10'h088, ref_regs[2], ref_regs[9], 32'h4, 4'd2, 4'd9, 4'd0, 15'h071));
        for (int i = 0; i < 2; i++) begin
            cyc();
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL store_decode step=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] instrs [4] = '{20'h42103, 20'h521FE, 20'h61000, 20'h730AB};
        ev_t         exps   [4];
        exps[0] = mk(10'h041, ref_regs[1], ref_regs[2], 32'h3,        4'd1, 4'd2,  4'd0, 15'h080);
        exps[1] = mk(10'h021, ref_regs[1], ref_regs[2], 32'hFFFFFFFE, 4'd1, 4'd2,  4'd0, 15'h081);
        exps[2] = mk(10'h210, 32'h0,       32'h0,       32'h0,        4'd0, 4'd0,  4'd1, 15'h082);
        exps[3] = mk(10'h208, 32'h0,       ref_regs[10], 32'h0000AB00, 4'd0, 4'd10, 4'd3, 15'h083);
        for (int i = 0; i < 4; i++) begin
            InstrD = instrs[i];
            PCD    = 15'(32'h080 + i);
            sb.push_back(exps[i]);
            cyc();
            got = observe(); exp_v = sb.pop_front(); checks++;
            if (got !== exp_v) begin
                failures++;
                $display("FAIL back_to_back idx=%0d got=%h exp=%h", i, got, exp_v);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        InstrD    = 20'hF0000;
        PCD       = '0;
        PCSrcE    = 1'b0;
        RegWriteW = 1'b0;
        RdW       = '0;
        ResultW   = '0;
        for (int i = 0; i < 16; i++) ref_regs[i] = '0;
        test_reset();
        test_writeback();
        test_bypass();
        test_load_use();
        test_flush();
        test_illegal_r0();
        test_store();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout time=%0t limit=100000", $time);
        $fatal(1);
    end

endmodule
